// File: rtl/pw_pkg.sv
// Shared definitions for the password sequencer and the lock model:
// state encoding, default parameter values and interval helpers.
package pw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PRESS     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_DONE      = 3'd5
    } pw_state_t;

    localparam int PW_WIDTH_DEF    = 8;
    localparam int MAX_LEN_DEF     = 8;
    localparam int HOLD_CYC_DEF    = 4;
    localparam int GAP_CYC_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 16;

    // Interval timers count 0..255 cycles
    localparam int TMR_W = 8;

    // The timer reports expiry on its last cycle, so an N-cycle interval loads N-1
    function automatic logic [TMR_W-1:0] interval_load(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pw_cycle_timer.sv
// Loadable down-counter shared by the HOLD, GAP and TIMEOUT intervals.
// Saturates at zero; expired is high while the count sits at zero.
module pw_cycle_timer
    import pw_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] remaining;

    // Reload on request, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/pw_sequencer.sv
// Password sequencer: buffers characters, then presents each one to the
// lock with a timed enter strobe and waits for an open/wrong verdict.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | accept writes/clear/start
// ST_SETUP     | one cycle, char_out settles before enter rises
// ST_PRESS     | enter high for HOLD_CYC cycles
// ST_RELEASE   | enter low for GAP_CYC cycles, then next char or wait
// ST_WAIT_RESP | wait up to TIMEOUT_CYC cycles for open_in / wrong_in
// ST_DONE      | one-cycle done pulse, then back to idle
module pw_sequencer
    import pw_pkg::*;
#(
    parameter int PW_WIDTH    = PW_WIDTH_DEF,
    parameter int MAX_LEN     = MAX_LEN_DEF,
    parameter int HOLD_CYC    = HOLD_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [PW_WIDTH-1:0]            wr_char,
    input  logic                           clear,
    input  logic                           start,
    input  logic                           open_in,
    input  logic                           wrong_in,
    output logic [PW_WIDTH-1:0]            char_out,
    output logic                           enter,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [$clog2(MAX_LEN+1)-1:0]   count
);

    localparam int COUNT_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(MAX_LEN);

    pw_state_t             state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    idx_q, idx_d;
    logic                  pass_d, fail_d, timeout_d;
    logic                  wr_buf;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_expired;
    logic [PW_WIDTH-1:0]   char_buf [MAX_LEN];

    pw_cycle_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next-state, buffer bookkeeping and result flags
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        pass_d    = pass;
        fail_d    = fail;
        timeout_d = timeout;
        wr_buf    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    count_d   = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (start) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    if (count_q == '0) begin
                        fail_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        fail_d  = 1'b0;
                        idx_d   = '0;
                        state_d = ST_SETUP;
                    end
                end else if (wr_en && count_q < FULL) begin
                    wr_buf  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            ST_SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = interval_load(HOLD_CYC);
                state_d  = ST_PRESS;
            end
            ST_PRESS: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = interval_load(GAP_CYC);
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (tmr_expired) begin
                    if (idx_q + 1'b1 < count_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = interval_load(TIMEOUT_CYC);
                        state_d  = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (open_in) begin
                    pass_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (wrong_in) begin
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, buffer and output registers; outputs decode the next state so
    // they change cleanly on the clock edge together with the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            enter    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            char_out <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                char_buf[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            pass    <= pass_d;
            fail    <= fail_d;
            timeout <= timeout_d;
            enter   <= (state_d == ST_PRESS);
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
            if (state_d == ST_SETUP) begin
                char_out <= char_buf[idx_d[IDX_W-1:0]];
            end
            if (wr_buf) begin
                char_buf[count_q[IDX_W-1:0]] <= wr_char;
            end
        end
    end

    assign count = count_q;

endmodule

// File: doc/pw_sequencer.md
PW_SEQUENCER -- requirements
Module: pw_sequencer

Interface
REQ-001 Parameter PW_WIDTH, 8, bits per password character.
REQ-002 Parameter MAX_LEN, 8, character buffer depth; legal range 1..16.
REQ-003 Parameter HOLD_CYC, 4, cycles enter is held high per character; legal range 1..255.
REQ-004 Parameter GAP_CYC, 4, cycles enter is held low after each release; legal range 1..255.
REQ-005 Parameter TIMEOUT_CYC, 16, maximum cycles to wait for a lock verdict; legal range 1..255.
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  appends wr_char to the buffer.
REQ-009 wr_char  in  PW_WIDTH  character to append.
REQ-010 clear  in  1  empties the buffer and clears result flags.
REQ-011 start  in  1  begins sending the buffered sequence.
REQ-012 open_in  in  1  open indication from the lock.
REQ-013 wrong_in  in  1  wrong indication from the lock.
REQ-014 char_out  out  PW_WIDTH  character presented to the lock.
REQ-015 enter  out  1  enter strobe to the lock.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when a sequence completes.
REQ-018 pass, fail, timeout  out  1 each  sticky result flags.
REQ-019 count  out  clog2(MAX_LEN+1)  number of buffered characters.

Function
REQ-020 States: IDLE, SETUP, PRESS, RELEASE, WAIT_RESP, DONE.
REQ-021 Buffer writes:
- In IDLE, wr_en with count<MAX_LEN stores the character at index count and increments count.
- wr_en is ignored when count==MAX_LEN or when not in IDLE.
REQ-022 clear takes effect in IDLE only:
- sets count to 0 and clears pass/fail/timeout;
- takes priority over a simultaneous wr_en or start.
REQ-023 start in IDLE:
- count==0: go to DONE and set fail.
- otherwise: load index 0, clear pass/fail/timeout, go to SETUP.
REQ-024 SETUP lasts 1 cycle with char_out driving the current character and enter=0, then goes to PRESS.
REQ-025 PRESS holds enter=1 for exactly HOLD_CYC cycles, then goes to RELEASE.
REQ-026 RELEASE holds enter=0 for GAP_CYC cycles, then:
- if index<count-1: increment index and go to SETUP;
- otherwise: go to WAIT_RESP.
REQ-027 char_out stays stable from SETUP through the end of RELEASE for each character.
REQ-028 WAIT_RESP exits on the first of these events:
- open_in=1: set pass, go to DONE;
- wrong_in=1: set fail, go to DONE;
- TIMEOUT_CYC cycles with neither: set timeout, go to DONE.
REQ-029 If open_in and wrong_in are high in the same cycle, pass takes priority.
REQ-030 open_in and wrong_in are ignored outside WAIT_RESP.
REQ-031 DONE lasts 1 cycle with done=1, then returns to IDLE; the buffer and count are preserved so the sequence can be resent.
REQ-032 start outside IDLE is ignored; at most one of pass/fail/timeout is set at a time.
REQ-033 All outputs are registered; enter never glitches.
REQ-034 All counters saturate or reload and never wrap.

Reset
REQ-035 While reset_n=0:
- state is IDLE;
- count, index and all cycle counters are 0;
- char_out=0; enter, busy, done, pass, fail and timeout are 0.
REQ-036 Reset asserted mid-sequence drops enter in the same cycle (asynchronously) and discards the buffer contents.

Structure
REQ-037 State encodings and default parameter values live in shared package pw_pkg, which the lock FSM also uses.
REQ-038 One sub-module, pw_cycle_timer, implements the loadable down-counter reused for the HOLD, GAP and TIMEOUT intervals.

Verification
REQ-039 Load 0x48, start, lock asserts open_in 2 cycles after entering WAIT_RESP -> char_out=0x48, enter high for exactly 4 cycles, pass=1, done pulses once.
REQ-040 Load 0x41, start, lock asserts wrong_in -> fail=1, pass=0, busy drops the cycle after done.
REQ-041 Load 3 characters 0x31, 0x32, 0x33, start -> three enter pulses of 4 cycles each, separated by a 4-cycle gap plus 1 SETUP cycle; char_out is stable during each pulse.
REQ-042 Load 1 character, start, no response -> timeout=1 exactly 16 cycles after entering WAIT_RESP.
REQ-043 Start with an empty buffer -> done and fail on the next cycle; writes beyond MAX_LEN leave count=8.
REQ-044 Assert reset_n=0 during PRESS -> enter drops immediately, all outputs return to 0, and count=0.
